// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and the arbiter that time-shares it:
// opcodes, sequencer states and flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_0000 = 4'b0000;  // add
    localparam logic [3:0] OP_0001 = 4'b0001;  // sub
    localparam logic [3:0] OP_0010 = 4'b0010;  // and
    localparam logic [3:0] OP_0011 = 4'b0011;  // or
    localparam logic [3:0] OP_0100 = 4'b0100;  // xor
    localparam logic [3:0] OP_0101 = 4'b0101;  // not a
    localparam logic [3:0] OP_0110 = 4'b0110;  // shift left a
    localparam logic [3:0] OP_0111 = 4'b0111;  // logical shift right a
    localparam logic [3:0] OP_1000 = 4'b1000;  // arithmetic shift right a
    localparam logic [3:0] OP_1001 = 4'b1001;  // rotate left a
    localparam logic [3:0] OP_1010 = 4'b1010;  // rotate right a
    localparam logic [3:0] OP_1011 = 4'b1011;  // increment a
    localparam logic [3:0] OP_1100 = 4'b1100;  // decrement a
    localparam logic [3:0] OP_MAX  = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    // Flag vector layout is {carry, overflow, zero, negative}.
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU. Carry on subtract/decrement means borrow; shifts
// put the bit shifted out into carry. Illegal opcodes produce a zero result.
module alu
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] op,
    output logic [3:0] result,
    output logic [3:0] flags
);

    logic [4:0] wide;
    logic       c;
    logic       v;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (that would infer a latch).
        wide   = '0;
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_0000: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[3:0];
                c      = wide[4];
                v      = (a[3] == b[3]) && (result[3] != a[3]);
            end
            OP_0001: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[3:0];
                c      = wide[4];
                v      = (a[3] != b[3]) && (result[3] != a[3]);
            end
            OP_0010: result = a & b;
            OP_0011: result = a | b;
            OP_0100: result = a ^ b;
            OP_0101: result = ~a;
            OP_0110: begin
                result = {a[2:0], 1'b0};
                c      = a[3];
            end
            OP_0111: begin
                result = {1'b0, a[3:1]};
                c      = a[0];
            end
            OP_1000: begin
                result = {a[3], a[3:1]};
                c      = a[0];
            end
            OP_1001: result = {a[2:0], a[3]};
            OP_1010: result = {a[0], a[3:1]};
            OP_1011: begin
                wide   = {1'b0, a} + 5'd1;
                result = wide[3:0];
                c      = wide[4];
                v      = (a == 4'b0111);
            end
            OP_1100: begin
                wide   = {1'b0, a} - 5'd1;
                result = wide[3:0];
                c      = wide[4];
                v      = (a == 4'b1000);
            end
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
        flags[FLAG_Z] = (result == 4'b0000);
        flags[FLAG_N] = result[3];
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin one-hot picker: the search starts just after the last served
// requester and wraps, so the most recently served one has lowest priority.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == (int'(last) + k) % NREQ)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NREQ requesters: accept one request in IDLE, compute in
// EXEC, hold the registered response in RESP until the consumer takes it.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_a,
    input  logic [4*NREQ-1:0]    req_b,
    input  logic [4*NREQ-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [3:0]           rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err,
    output logic [7:0]           op_count
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [3:0]      a_q, a_d, b_q, b_d, op_q, op_d;
    logic [3:0]      rsp_result_q, rsp_result_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic            rsp_err_q, rsp_err_d;
    logic [7:0]      op_count_q, op_count_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  pick_id;
    logic [3:0]      alu_result;
    logic [3:0]      alu_flags;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) pick_id = IDW'(i);
        end
    end

    assign req_ready  = (state_q == IDLE) ? grant : '0;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        gnt_id_d     = gnt_id_q;
        rsp_id_d     = rsp_id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                // Any valid yields a grant, so a nonzero grant is the handshake.
                if (|grant) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant[i]) begin
                            a_d  = req_a[4*i +: 4];
                            b_d  = req_b[4*i +: 4];
                            op_d = req_op[4*i +: 4];
                        end
                    end
                    gnt_id_d = pick_id;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_id_d = gnt_id_q;
                if (op_illegal(op_q)) begin
                    rsp_result_d = '0;
                    rsp_flags_d  = '0;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_err_d    = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                // Priority moves only once the response has actually been taken.
                if (rsp_ready) begin
                    last_d     = gnt_id_q;
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples its _d value from before the edge.
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= IDW'(NREQ - 1);
            gnt_id_q     <= '0;
            rsp_id_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gnt_id_q     <= gnt_id_d;
            rsp_id_q     <= rsp_id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a table of single-requester operations with
// hand-computed results, then round-robin, backpressure, reset and wrap sequences.
module tb_alu_share_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [4*NREQ-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_err;
    logic [7:0]        op_count;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [3:0] res;
        logic [3:0] flags;
        logic       err;
    } vec_t;

    vec_t vq[$];

    alu_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int id);
        logic [NREQ-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) if (i == id) v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        for (int i = 0; i < NREQ; i++) begin
            if (i == id) begin
                req_a[4*i +: 4]  = a;
                req_b[4*i +: 4]  = b;
                req_op[4*i +: 4] = op;
            end
        end
    endtask

    task automatic add_vec(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                           input logic [3:0] res, input logic [3:0] flags, input logic err);
        vec_t v;
        v.id = id; v.a = a; v.b = b; v.op = op; v.res = res; v.flags = flags; v.err = err;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One complete transaction from a single requester with full latency checks.
    task automatic run_vec(input int k, input vec_t v, input int exp_cnt);
        bit got;
        @(posedge clk);
        #1;
        set_req(v.id, v.a, v.b, v.op);
        req_valid = onehot(v.id);
        got = 0;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = 1;
                break;
            end
        end
        check($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(onehot(v.id)));
        if (!got) begin
            req_valid = '0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        req_a  = ~req_a;
        req_b  = ~req_b;
        req_op = ~req_op;
        @(negedge clk);
        check($sformatf("vec%0d_valid_t1", k), 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check($sformatf("vec%0d_valid_t2", k), 32'(rsp_valid), 32'd1);
        check($sformatf("vec%0d_id", k), 32'(rsp_id), 32'(v.id));
        check($sformatf("vec%0d_result", k), 32'(rsp_result), 32'(v.res));
        check($sformatf("vec%0d_flags", k), 32'(rsp_flags), 32'(v.flags));
        check($sformatf("vec%0d_err", k), 32'(rsp_err), 32'(v.err));
        check($sformatf("vec%0d_ready_busy", k), 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check($sformatf("vec%0d_count", k), 32'(op_count), exp_cnt);
        check($sformatf("vec%0d_valid_done", k), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int  prev;
        int  n;
        int  bad;
        bit  seen;

        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = '0;

        // id, a, b, op, result, flags {c,v,z,n}, err
        add_vec(0, 4'b1010, 4'b0110, 4'b0000, 4'b0000, 4'b1010, 1'b0);  // add wraps to zero
        add_vec(1, 4'b0111, 4'b0001, 4'b0000, 4'b1000, 4'b0101, 1'b0);  // add signed overflow
        add_vec(0, 4'b0011, 4'b0101, 4'b0001, 4'b1110, 4'b1001, 1'b0);  // sub borrow
        add_vec(1, 4'b1000, 4'b0001, 4'b0001, 4'b0111, 4'b0100, 1'b0);  // sub signed overflow
        add_vec(0, 4'b1100, 4'b1010, 4'b0010, 4'b1000, 4'b0001, 1'b0);
        add_vec(1, 4'b0101, 4'b0011, 4'b0011, 4'b0111, 4'b0000, 1'b0);
        add_vec(0, 4'b1111, 4'b1111, 4'b0100, 4'b0000, 4'b0010, 1'b0);
        add_vec(1, 4'b0101, 4'b0000, 4'b0101, 4'b1010, 4'b0001, 1'b0);
        add_vec(0, 4'b1001, 4'b0000, 4'b0110, 4'b0010, 4'b1000, 1'b0);
        add_vec(1, 4'b1001, 4'b0000, 4'b0111, 4'b0100, 4'b1000, 1'b0);
        add_vec(0, 4'b1001, 4'b0000, 4'b1000, 4'b1100, 4'b1001, 1'b0);
        add_vec(1, 4'b1001, 4'b0000, 4'b1001, 4'b0011, 4'b0000, 1'b0);
        add_vec(0, 4'b1001, 4'b0000, 4'b1010, 4'b1100, 4'b0001, 1'b0);
        add_vec(1, 4'b1111, 4'b0000, 4'b1011, 4'b0000, 4'b1010, 1'b0);
        add_vec(0, 4'b1000, 4'b0000, 4'b1100, 4'b0111, 4'b0100, 1'b0);
        add_vec(1, 4'b0011, 4'b0011, 4'b1101, 4'b0000, 4'b0000, 1'b1);  // illegal ops
        add_vec(0, 4'b1010, 4'b0110, 4'b1110, 4'b0000, 4'b0000, 1'b1);
        add_vec(1, 4'b0111, 4'b0000, 4'b1011, 4'b1000, 4'b0101, 1'b0);  // normal after illegal

        @(posedge clk);
        do_reset();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);

        for (int k = 0; k < vq.size(); k++) run_vec(k, vq[k], k + 1);

        // Round-robin with both requesters valid and the consumer always ready.
        do_reset();
        set_req(0, 4'b0110, 4'b0011, 4'b0001);
        set_req(1, 4'b0110, 4'b0011, 4'b0010);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rr_first_grant", 32'(req_ready), 32'b01);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int w = 0; w < 8; w++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    seen = 1;
                    break;
                end
            end
            check($sformatf("rr%0d_seen", k), 32'(seen), 32'd1);
            check($sformatf("rr%0d_id", k), 32'(rsp_id), k % 2);
            check($sformatf("rr%0d_result", k), 32'(rsp_result), (k % 2 == 0) ? 32'b0011 : 32'b0010);
            if (k > 0) check($sformatf("rr%0d_spacing", k), cyc - prev, 32'd3);
            prev = cyc;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b0;
        check("rr_count", 32'(op_count), 32'd4);

        // Backpressure: response held for 5 cycles while both requesters wait.
        set_req(0, 4'b0001, 4'b0010, 4'b0000);
        req_valid = 2'b01;
        @(negedge clk);
        check("bp_grant", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid", 32'(rsp_valid), 32'd1);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d_result", i), 32'(rsp_result), 32'b0011);
            check($sformatf("bp%0d_flags", i), 32'(rsp_flags), 32'b0000);
            check($sformatf("bp%0d_id", i), 32'(rsp_id), 32'd0);
            check($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("bp%0d_count", i), 32'(op_count), 32'd4);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        check("bp_done_count", 32'(op_count), 32'd5);
        check("bp_done_valid", 32'(rsp_valid), 32'd0);

        // Reset during EXEC discards the operation and restores requester-0 priority.
        do_reset();
        run_vec(100, vq[0], 1);
        set_req(0, 4'b0001, 4'b0001, 4'b0000);
        req_valid = 2'b01;
        @(negedge clk);
        check("rx_grant", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("rx_no_rsp", 32'(seen), 32'd0);
        check("rx_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1 req_valid = 2'b11;
        @(negedge clk);
        check("rx_prio", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("rx_rsp_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("rx_count_after", 32'(op_count), 32'd1);

        // 256 back-to-back completions wrap the counter to zero.
        do_reset();
        set_req(0, 4'b0001, 4'b0001, 4'b0000);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        n = 0;
        bad = 0;
        prev = 0;
        for (int c = 0; c < 1000 && n < 256; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n++;
                if (n > 1 && cyc - prev != 3) bad++;
                if (rsp_result != 4'b0010) bad++;
                prev = cyc;
                if (n == 256) check("wrap_pre_count", 32'(op_count), 32'hFF);
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b0;
        check("wrap_responses", n, 32'd256);
        check("wrap_spacing", bad, 32'd0);
        check("wrap_count", 32'(op_count), 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("wrap_quiet", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares one 4-bit `alu` instance among `NREQ` requesters. Each requester presents operands and an opcode over a valid/ready channel. The block grants one requester at a time, drives the shared ALU, registers its result and flags, and returns them on a single response channel tagged with the requester index. It sits between the control units and the combinational ALU datapath.

## Interface
- `NREQ`, default 2: number of requesters (2..8).
- `IDW`, default 3: width of the requester ID; must satisfy 2**IDW >= NREQ.
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit is set.
- `req_a`  in  4*NREQ  operand a, packed; requester i uses bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand b, packed the same way.
- `req_op`  in  4*NREQ  opcode, packed the same way.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_id`  out  IDW  index of the granted requester.
- `rsp_result`  out  4  ALU result.
- `rsp_flags`  out  4  {carry, overflow, zero, negative}.
- `rsp_err`  out  1  illegal opcode (op > 4'b1100).
- `op_count`  out  8  completed responses; wraps modulo 256.

## Operation
- FSM states:
  - IDLE: compute the grant g by round-robin search starting at `last+1` (mod NREQ). If any `req_valid` is set, assert `req_ready[g]` combinationally. A handshake is `req_valid[g] && req_ready[g]`. On a handshake, latch a/b/op/g and go to EXEC.
  - EXEC: latched operands drive the ALU. At the clock edge, register result and flags into the response registers. For an illegal op, register result=0, flags=0 and err=1 instead. Go to RESP.
  - RESP: `rsp_valid`=1. When `rsp_ready`=1: set `last`=g, increment `op_count`, go to IDLE.
- `req_ready` is 0 in EXEC and RESP. A requester that drops `req_valid` in IDLE before the handshake is simply not granted.
- Response outputs stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- Operand or opcode changes at requester inputs after acceptance have no effect.
- Illegal opcodes 4'b1101..4'b1111 still consume a slot and produce a response with `rsp_err`=1.
- `op_count` wraps from 8'hFF to 8'h00.

## Timing
- Reset values:
  - state=IDLE, `last`=NREQ-1, so requester 0 has first priority.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_err`=0, `op_count`=0.
- Latency: handshake in cycle T, then `rsp_valid` is asserted from cycle T+2.
- Throughput: one operation every 3 cycles with `rsp_ready` held high. The next `req_ready` is earliest in the cycle after the response handshake.
- The round-robin pointer advances only on response completion, never on acceptance alone.
- Multiple simultaneous valids: exactly one grant per IDLE cycle; the others wait.
- `rst` asserted in any state returns to IDLE on the next edge. An in-flight operation is discarded with no response, and `op_count` is not incremented.
- `rsp_ready` asserted outside RESP is ignored.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_0000`..`OP_1100` and `OP_MAX`=4'b1100.
  - state enum {IDLE, EXEC, RESP}.
  - flag-bit index constants.
- One sub-module `rr_pick`: combinational round-robin one-hot picker with inputs `req`[NREQ] and `last` and a one-hot grant output.
- The existing `alu` is instantiated once inside, fed from the latched operand registers.

## Test plan
- Single requester: NREQ=2, req0 a=4'b1010, b=4'b0110, op=4'b0000. Required: handshake at T, `rsp_valid` at T+2, `rsp_id`=0, `rsp_result`/`rsp_flags` equal to a standalone `alu` given the same inputs, `op_count`=1.
- Both requesters valid continuously, `rsp_ready`=1, ops 4'b0001 (req0) and 4'b0010 (req1). Required: grant order 0,1,0,1; responses 3 cycles apart; ids alternate.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP. Required: `rsp_*` stable, both `req_ready` bits 0; completion in the cycle `rsp_ready` rises.
- Illegal op 4'b1110. Required: `rsp_err`=1, result=0, flags=0, `op_count` increments, and the next request is accepted normally.
- Reset in EXEC. Required: `rsp_valid` never asserted for that op, `op_count` unchanged at 0, requester 0 has priority afterwards.
- `op_count` wrap: 256 completed ops take it to 8'h00 with no glitch in `rsp_valid`.
